// File: rtl/hazard_pkg.sv
// Shared types and forwarding helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULDIV  = 2'd1,
    MEMWAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // The M stage holds the younger result, so it wins over W.
  function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
    logic [1:0] sel;
    sel = FWD_RF;
    if (m_hit) sel = FWD_M;
    else if (w_hit) sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_stall_cnt.sv
// Down-counter tracking the remaining execute-occupancy cycles of a mul/div.
module muldiv_stall_cnt
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_enable,
  input  logic i_freeze,
  output logic o_done
);

  localparam int CNT_W  = $clog2(MULDIV_LAT + 1);
  // The first stall cycle is spent in RUN, and the cycle at zero is the last one.
  localparam int LOAD_V = (MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0;

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_freeze) begin
      r_cnt <= r_cnt;
    end else if (i_load) begin
      r_cnt <= CNT_W'(LOAD_V);
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the five-stage core.
// HAZARD_FWD_EN enables operand forwarding; without it RAW hazards stall instead.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemReadE,
  input  logic                  PCSrcE,
  input  logic                  MulDivStartE,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE
);

  localparam bit MULTI_CYCLE = (MULDIV_LAT > 1);

  hz_state_t r_state, w_state_nxt;
  logic      r_saved_md, w_saved_md_nxt;
  logic      r_md_skip, w_md_skip_nxt;
  logic      w_mem_wait, w_eff_md, w_raw;
  logic      w_cnt_load, w_cnt_en, w_cnt_freeze, w_cnt_done;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_mem_wait = MemReqM && !MemReadyM;
  // Once memory completes, MEMWAIT behaves exactly like the state it interrupted.
  assign w_eff_md   = (r_state == MULDIV) || ((r_state == MEMWAIT) && r_saved_md);

`ifdef HAZARD_FWD_EN
  logic w_unused;
  assign w_unused = RegWriteE;
  assign w_raw    = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_fwd_a  = fwd_sel(RegWriteM && (RdM != '0) && (RdM == Rs1E),
                            RegWriteW && (RdW != '0) && (RdW == Rs1E));
  assign w_fwd_b  = fwd_sel(RegWriteM && (RdM != '0) && (RdM == Rs2E),
                            RegWriteW && (RdW != '0) && (RdW == Rs2E));
`else
  logic w_unused;
  assign w_unused = ^{MemReadE, Rs1E, Rs2E, RegWriteW, RdW};
  // W-stage producers are covered by the register file's write-before-read.
  assign w_raw    = (RegWriteE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D))) ||
                    (RegWriteM && (RdM != '0) && ((RdM == Rs1D) || (RdM == Rs2D)));
  assign w_fwd_a  = FWD_RF;
  assign w_fwd_b  = FWD_RF;
`endif

  muldiv_stall_cnt #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_cnt_load),
    .i_enable(w_cnt_en),
    .i_freeze(w_cnt_freeze),
    .o_done  (w_cnt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_saved_md <= 1'b0;
      r_md_skip  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_saved_md <= w_saved_md_nxt;
      r_md_skip  <= w_md_skip_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = RUN;
    w_saved_md_nxt = r_saved_md;
    w_md_skip_nxt  = r_md_skip;
    w_cnt_load     = 1'b0;
    w_cnt_en       = 1'b0;
    w_cnt_freeze   = 1'b0;
    StallF         = 1'b0;
    StallD         = 1'b0;
    StallE         = 1'b0;
    StallM         = 1'b0;
    FlushD         = 1'b0;
    FlushE         = 1'b0;
    FlushM         = 1'b0;
    FlushW         = 1'b0;
    ForwardAE      = FWD_RF;
    ForwardBE      = FWD_RF;

    if (!rst) begin
      ForwardAE = w_fwd_a;
      ForwardBE = w_fwd_b;

      if (w_mem_wait) begin
        StallF       = 1'b1;
        StallD       = 1'b1;
        StallE       = 1'b1;
        StallM       = 1'b1;
        FlushW       = 1'b1;
        w_cnt_freeze = 1'b1;
        w_state_nxt  = MEMWAIT;
        if (r_state != MEMWAIT) w_saved_md_nxt = (r_state == MULDIV);
      end else if (w_eff_md) begin
        StallF   = 1'b1;
        StallD   = 1'b1;
        StallE   = 1'b1;
        FlushM   = 1'b1;
        w_cnt_en = 1'b1;
        if (w_cnt_done) begin
          w_state_nxt   = RUN;
          w_md_skip_nxt = 1'b1;
        end else begin
          w_state_nxt = MULDIV;
        end
      end else begin
        // The finished mul/div still sits in E for one cycle; do not restart it.
        w_md_skip_nxt = 1'b0;
        if (MulDivStartE && !r_md_skip) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
          if (MULTI_CYCLE) begin
            w_state_nxt = MULDIV;
            w_cnt_load  = 1'b1;
          end else begin
            w_md_skip_nxt = 1'b1;
          end
        end else if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (w_raw) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

endmodule
